// File: rtl/beat_rate_estimator.sv
// Heartbeat peak detector (hysteresis + refractory window) that measures the
// inter-beat interval in samples and converts it to BPM with a restoring divider.
module beat_rate_estimator #(
    parameter int FS      = 100,
    parameter int HYST    = 8,
    parameter int MIN_IBI = 30,
    parameter int MAX_IBI = 300,
    parameter int DIV_W   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_valid,
    input  logic [9:0] sample,
    output logic       beat,
    output logic [7:0] bpm,
    output logic       bpm_valid,
    output logic       locked,
    output logic [7:0] beat_count
);

    localparam logic [DIV_W-1:0] NUMER     = DIV_W'(60 * FS);
    localparam logic [DIV_W-1:0] MIN_IBI_C = DIV_W'(MIN_IBI);
    localparam logic [DIV_W-1:0] MAX_IBI_C = DIV_W'(MAX_IBI);
    localparam logic [10:0]      HYST_C    = 11'(HYST);
    localparam int               STEP_W    = $clog2(DIV_W + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DIV_W - 1);

    typedef enum logic {RISE, FALL} peak_state_e;
    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

    peak_state_e       peak_q, peak_d;
    logic [9:0]        max_q, max_d;
    logic [9:0]        min_q, min_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic              have_first_q, have_first_d;
    logic              heard_q, heard_d;
    logic              beat_q, beat_d;
    logic [7:0]        beat_count_q, beat_count_d;
    div_state_e        div_q, div_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [DIV_W-1:0]  rem_q, rem_d;
    logic [DIV_W-1:0]  quo_q, quo_d;
    logic [DIV_W-1:0]  dvs_q, dvs_d;
    logic [7:0]        bpm_q, bpm_d;
    logic              bpm_valid_q, bpm_valid_d;

    logic [DIV_W-1:0]  ibi_now;
    logic              peak_found;
    logic              accepted;
    logic              timeout;
    logic [DIV_W:0]    shifted;
    logic [DIV_W:0]    trial;
    logic [7:0]        bpm_sat;

    always_comb begin
        ibi_now    = cnt_q + 1'b1;
        peak_found = sample_valid && (peak_q == RISE)
                     && (({1'b0, sample} + HYST_C) <= {1'b0, max_q});
        accepted   = peak_found && (!have_first_q || (ibi_now >= MIN_IBI_C));
        // An accepted peak on the timeout sample suppresses the timeout.
        timeout    = sample_valid && have_first_q && !peak_found && (ibi_now == MAX_IBI_C);
        shifted    = {rem_q, quo_q[DIV_W-1]};
        trial      = shifted - {1'b0, dvs_q};
        bpm_sat    = (|quo_q[DIV_W-1:8]) ? 8'hFF : quo_q[7:0];
    end

    // Peak FSM, interval counter and beat bookkeeping; advance only on valid samples.
    always_comb begin
        peak_d       = peak_q;
        max_d        = max_q;
        min_d        = min_q;
        cnt_d        = cnt_q;
        have_first_d = have_first_q;
        beat_d       = 1'b0;
        beat_count_d = beat_count_q;
        if (sample_valid) begin
            case (peak_q)
                RISE: begin
                    if (peak_found) begin
                        peak_d = FALL;
                        min_d  = sample;
                    end else if (sample > max_q) begin
                        max_d = sample;
                    end
                end
                default: begin
                    if ({1'b0, sample} >= ({1'b0, min_q} + HYST_C)) begin
                        peak_d = RISE;
                        max_d  = sample;
                    end else if (sample < min_q) begin
                        min_d = sample;
                    end
                end
            endcase
            if (accepted) begin
                cnt_d        = '0;
                beat_d       = 1'b1;
                beat_count_d = beat_count_q + 8'd1;
                have_first_d = 1'b1;
            end else begin
                cnt_d = (ibi_now >= MAX_IBI_C) ? MAX_IBI_C : ibi_now;
            end
            if (timeout) begin
                have_first_d = 1'b0;
            end
        end
    end

    // Divider: load on the accepting edge, DIV_W restoring steps, then publish.
    always_comb begin
        div_d       = div_q;
        step_d      = step_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        bpm_d       = bpm_q;
        bpm_valid_d = 1'b0;
        case (div_q)
            DIV_IDLE: begin
                if (accepted && have_first_q) begin
                    div_d  = DIV_RUN;
                    step_d = '0;
                    rem_d  = '0;
                    quo_d  = NUMER;
                    dvs_d  = ibi_now;
                end
            end
            DIV_RUN: begin
                if (trial[DIV_W]) begin
                    rem_d = shifted[DIV_W-1:0];
                    quo_d = {quo_q[DIV_W-2:0], 1'b0};
                end else begin
                    rem_d = trial[DIV_W-1:0];
                    quo_d = {quo_q[DIV_W-2:0], 1'b1};
                end
                step_d = step_q + 1'b1;
                if (step_q == LAST_STEP) begin
                    div_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                div_d       = DIV_IDLE;
                bpm_d       = bpm_sat;
                bpm_valid_d = 1'b1;
            end
            default: div_d = DIV_IDLE;
        endcase
        if (timeout) begin
            div_d       = DIV_IDLE;
            bpm_d       = '0;
            bpm_valid_d = 1'b1;
        end
    end

    // heard: a nonzero rate has been published since the first beat of this lock.
    always_comb begin
        heard_d = heard_q;
        if (accepted && !have_first_q) begin
            heard_d = 1'b0;
        end else if ((div_q == DIV_DONE) && !timeout && (bpm_sat != 8'd0)) begin
            heard_d = 1'b1;
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_q       <= RISE;
            max_q        <= '0;
            min_q        <= 10'd1023;
            cnt_q        <= '0;
            have_first_q <= 1'b0;
            heard_q      <= 1'b0;
            beat_q       <= 1'b0;
            beat_count_q <= '0;
            div_q        <= DIV_IDLE;
            step_q       <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvs_q        <= '0;
            bpm_q        <= '0;
            bpm_valid_q  <= 1'b0;
        end else begin
            peak_q       <= peak_d;
            max_q        <= max_d;
            min_q        <= min_d;
            cnt_q        <= cnt_d;
            have_first_q <= have_first_d;
            heard_q      <= heard_d;
            beat_q       <= beat_d;
            beat_count_q <= beat_count_d;
            div_q        <= div_d;
            step_q       <= step_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            dvs_q        <= dvs_d;
            bpm_q        <= bpm_d;
            bpm_valid_q  <= bpm_valid_d;
        end
    end

    assign beat       = beat_q;
    assign bpm        = bpm_q;
    assign bpm_valid  = bpm_valid_q;
    assign beat_count = beat_count_q;
    assign locked     = have_first_q & heard_q;

endmodule

// File: tb/tb_beat_rate_estimator.sv
// Bench for beat_rate_estimator: table-driven waveform vectors, directed corner
// sequences, and random waveforms checked against an event-level reference model.
`timescale 1ns/1ps
module tb_beat_rate_estimator;

    localparam int HYST    = 8;
    localparam int MIN_IBI = 30;
    localparam int MAX_IBI = 300;
    localparam int DIV_W   = 16;
    localparam int NUMER   = 6000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_valid = 1'b0;
    logic [9:0] sample = '0;
    logic       beat, bpm_valid, locked;
    logic [7:0] bpm, beat_count;

    logic       s_valid = 1'b0;
    logic [9:0] s_sample = '0;
    logic       s_beat, s_bpm_valid, s_locked;
    logic [7:0] s_bpm, s_beat_count;

    beat_rate_estimator dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
        .beat(beat), .bpm(bpm), .bpm_valid(bpm_valid), .locked(locked),
        .beat_count(beat_count)
    );

    beat_rate_estimator #(.MIN_IBI(20)) dut_sat (
        .clk(clk), .reset(reset), .sample_valid(s_valid), .sample(s_sample),
        .beat(s_beat), .bpm(s_bpm), .bpm_valid(s_bpm_valid), .locked(s_locked),
        .beat_count(s_beat_count)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: applies the detection rules per sample and records the
    // clock edge at which each beat / bpm update must become visible.
    int exp_beat[int];
    int exp_bpm[int];
    bit m_rise, m_have;
    int m_max, m_min, m_cnt, m_count, m_div_start;

    function automatic void model_reset();
        m_rise = 1; m_have = 0; m_max = 0; m_min = 1023;
        m_cnt = 0; m_count = 0; m_div_start = -1;
        exp_beat.delete();
        exp_bpm.delete();
    endfunction

    function automatic void model_step(int s, int e);
        int ibi, q;
        bit peak;
        int doomed[$];
        ibi  = m_cnt + 1;
        peak = 0;
        if (m_rise) begin
            if (s + HYST <= m_max) begin peak = 1; m_rise = 0; m_min = s; end
            else if (s > m_max) m_max = s;
        end else begin
            if (s >= m_min + HYST) begin m_rise = 1; m_max = s; end
            else if (s < m_min) m_min = s;
        end
        if (peak && (!m_have || ibi >= MIN_IBI)) begin
            m_cnt = 0;
            m_count++;
            exp_beat[e] = m_count % 256;
            if (!m_have) m_have = 1;
            else if (m_div_start < 0 || e - m_div_start > DIV_W + 1) begin
                m_div_start = e;
                q = NUMER / ibi;
                exp_bpm[e + DIV_W + 1] = (q > 255) ? 255 : q;
            end
        end else begin
            m_cnt = (ibi > MAX_IBI) ? MAX_IBI : ibi;
            if (m_have && ibi == MAX_IBI) begin
                foreach (exp_bpm[k]) if (k >= e) doomed.push_back(k);
                foreach (doomed[i]) exp_bpm.delete(doomed[i]);
                exp_bpm[e] = 0;
                m_have = 0;
                m_div_start = -1;
            end
        end
    endfunction

    int n_beat = 0, n_bpmv = 0, last_bpm = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (beat === 1'b1 || exp_beat.exists(edge_cnt)) begin
                check("beat_pulse", beat, exp_beat.exists(edge_cnt));
                if (exp_beat.exists(edge_cnt)) check("beat_count_at_beat", beat_count, exp_beat[edge_cnt]);
            end
            if (bpm_valid === 1'b1 || exp_bpm.exists(edge_cnt)) begin
                check("bpm_valid_pulse", bpm_valid, exp_bpm.exists(edge_cnt));
                if (exp_bpm.exists(edge_cnt)) check("bpm_value", bpm, exp_bpm[edge_cnt]);
            end
            if (beat === 1'b1) n_beat++;
            if (bpm_valid === 1'b1) begin n_bpmv++; last_bpm = bpm; end
        end
    end

    // Called on a falling edge; the sample is taken on the next rising edge.
    task automatic send(input int v, input int gap);
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        model_step(v, edge_cnt + 1);
        sample = 10'(v);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic spike(input int lead);
        repeat (lead - 1) send(100, 1);
        send(300, 1);
    endtask

    task automatic s_send(input int v);
        s_sample = 10'(v);
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        model_reset();
        reset = 1'b1;
        #1;
        check("rst_beat", beat, 0);
        check("rst_bpm", bpm, 0);
        check("rst_bpm_valid", bpm_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_beat_count", beat_count, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic int tri_val(int p, int per, int amp);
        int h;
        h = per / 2;
        if (p <= h) return amp * p / h;
        return amp * (per - p) / (per - h);
    endfunction

    function automatic int noise(int n);
        return int'($urandom_range(0, 2 * n)) - n;
    endfunction

    typedef struct {
        int period;
        int gap;
        int reps;
        int exp_bpm;
        int exp_beats;
        int exp_bpmv;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int b0, v0, target, pend, got_v, got_bpm;
        vecs[0] = '{75, 16, 5, 80, 5, 4};
        vecs[1] = '{60, 1, 4, 100, 4, 3};
        vecs[2] = '{40, 2, 4, 150, 4, 3};
        vecs[3] = '{120, 1, 3, 50, 3, 2};
        vecs[4] = '{31, 1, 4, 193, 4, 3};
        model_reset();

        // Triangle waveforms 0->400->0 with fixed period.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            b0 = n_beat; v0 = n_bpmv;
            for (int r = 0; r < vecs[i].reps; r++)
                for (int p = 0; p < vecs[i].period; p++)
                    send(tri_val(p, vecs[i].period, 400), vecs[i].gap);
            repeat (5) send(0, vecs[i].gap);
            settle(DIV_W + 4);
            check("vec_beats", n_beat - b0, vecs[i].exp_beats);
            check("vec_bpm_valids", n_bpmv - v0, vecs[i].exp_bpmv);
            check("vec_bpm", last_bpm, vecs[i].exp_bpm);
            check("vec_bpm_port", bpm, vecs[i].exp_bpm);
            check("vec_locked", locked, 1);
            check("vec_beat_count", beat_count, vecs[i].exp_beats);
        end

        // Flat input with noise whose peak-to-peak stays below HYST.
        do_reset();
        b0 = n_beat; v0 = n_bpmv;
        for (int k = 0; k < 250; k++) send(200 + int'($urandom_range(0, 7)) - 4, int'($urandom_range(1, 3)));
        settle(20);
        check("noise_beats", n_beat - b0, 0);
        check("noise_bpm_valids", n_bpmv - v0, 0);
        check("noise_beat_count", beat_count, 0);

        // Refractory: a peak 20 samples after the first is ignored.
        do_reset();
        b0 = n_beat; v0 = n_bpmv;
        repeat (5) send(100, 1);
        spike(1); spike(20); spike(60);
        repeat (30) send(100, 1);
        settle(5);
        check("refr_beats", n_beat - b0, 2);
        check("refr_bpm_valids", n_bpmv - v0, 1);
        check("refr_bpm", last_bpm, 75);
        check("refr_locked", locked, 1);

        // MIN_IBI boundary: interval 30 accepted, 29 rejected.
        do_reset();
        b0 = n_beat; v0 = n_bpmv;
        repeat (5) send(100, 1);
        spike(1); spike(30); spike(29);
        repeat (30) send(100, 1);
        settle(5);
        check("minibi_beats", n_beat - b0, 2);
        check("minibi_bpm_valids", n_bpmv - v0, 1);
        check("minibi_bpm", last_bpm, 200);

        // Timeout after MAX_IBI samples without a beat.
        do_reset();
        repeat (5) send(100, 1);
        spike(1); spike(75);
        repeat (20) send(100, 1);
        settle(3);
        check("to_bpm_before", bpm, 80);
        check("to_locked_before", locked, 1);
        v0 = n_bpmv;
        @(negedge clk);
        repeat (300) send(100, 1);
        settle(3);
        check("to_bpm_valids", n_bpmv - v0, 1);
        check("to_bpm", bpm, 0);
        check("to_locked_after", locked, 0);
        b0 = n_beat; v0 = n_bpmv;
        @(negedge clk);
        spike(10);
        repeat (40) send(100, 1);
        settle(3);
        check("to_next_beats", n_beat - b0, 1);
        check("to_next_bpm_valids", n_bpmv - v0, 0);
        check("to_next_locked", locked, 0);

        // Reset in the middle of a division.
        do_reset();
        repeat (5) send(100, 1);
        spike(1); spike(75);
        send(100, 1);
        check("rdiv_started", m_div_start, edge_cnt);
        target = m_div_start + 4;
        for (int k = 0; k < 20 && edge_cnt < target; k++) @(negedge clk);
        check("rdiv_wait", edge_cnt, target);
        do_reset();
        v0 = n_bpmv;
        settle(40);
        check("rdiv_no_bpm_valid", n_bpmv - v0, 0);
        @(negedge clk);
        repeat (5) send(100, 1);
        spike(1); spike(75);
        repeat (25) send(100, 1);
        settle(3);
        check("rdiv_resume_bpm", bpm, 80);
        check("rdiv_resume_locked", locked, 1);

        // Random waveforms against the reference model.
        do_reset();
        for (int seg = 0; seg < 30; seg++) begin
            int kind, len, base, per, amp, reps, nz;
            kind = int'($urandom_range(0, 2));
            base = int'($urandom_range(50, 300));
            nz   = int'($urandom_range(0, 3));
            if (kind == 0) begin
                len = int'($urandom_range(40, 340));
                for (int k = 0; k < len; k++) send(base + noise(nz), int'($urandom_range(1, 3)));
            end else begin
                per  = int'($urandom_range(20, 160));
                amp  = int'($urandom_range(40, 600));
                reps = int'($urandom_range(1, 4));
                for (int r = 0; r < reps; r++)
                    for (int p = 0; p < per; p++)
                        send(base + tri_val(p, per, amp) + noise(nz), int'($urandom_range(1, 3)));
            end
        end
        settle(DIV_W + 10);
        pend = 0;
        foreach (exp_bpm[k]) if (k > edge_cnt) pend++;
        foreach (exp_beat[k]) if (k > edge_cnt) pend++;
        check("rand_pending_events", pend, 0);
        check("rand_beat_count", beat_count, m_count % 256);

        // Saturation with MIN_IBI lowered to 20: 6000/23 = 260 -> 255.
        do_reset();
        repeat (5) s_send(100);
        s_send(300);
        repeat (22) s_send(100);
        s_send(300);
        got_v = 0; got_bpm = 0;
        for (int k = 0; k < 40; k++) begin
            s_send(100);
            if (s_bpm_valid === 1'b1) begin got_v++; got_bpm = s_bpm; end
        end
        check("sat_bpm_valids", got_v, 1);
        check("sat_bpm", got_bpm, 255);
        check("sat_locked", s_locked, 1);
        check("sat_beat_count", s_beat_count, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at edge %0d", edge_cnt);
        $fatal(1, "watchdog");
    end

endmodule
